// File: rtl/attn_pkg.sv
// Shared constants, FSM state encoding and operand-select helper for the
// attention core I/O stager.
package attn_pkg;

  localparam int WORD_W      = 16;
  localparam int N_WORDS     = 32;
  localparam int MAT_W       = WORD_W * N_WORDS;
  localparam int TOTAL_WORDS = 3 * N_WORDS;

  localparam logic [6:0] KEY_BASE   = 7'd0;
  localparam logic [6:0] VALUE_BASE = 7'd32;
  localparam logic [6:0] QUERY_BASE = 7'd64;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_KEY   = 2'd0,
    SEL_VALUE = 2'd1,
    SEL_QUERY = 2'd2
  } op_sel_t;

  // Which operand bus the k-th loaded word belongs to.
  function automatic op_sel_t op_sel(input logic [6:0] wc);
    if (wc >= QUERY_BASE)      return SEL_QUERY;
    else if (wc >= VALUE_BASE) return SEL_VALUE;
    else                       return SEL_KEY;
  endfunction

endpackage

// File: rtl/attn_out_serializer.sv
// Captures the core's 512-bit result and emits it as N_WORDS registered
// words on a valid/ready stream, pulsing done on the final handshake.
module attn_out_serializer #(
  parameter int WORD_W  = attn_pkg::WORD_W,
  parameter int N_WORDS = attn_pkg::N_WORDS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      capture,
  input  logic [WORD_W*N_WORDS-1:0] res,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_data,
  output logic                      out_last,
  output logic                      done
);

  localparam int IDX_W = $clog2(N_WORDS);

  logic [WORD_W*N_WORDS-1:0] res_buf_q;
  logic [IDX_W-1:0]          rc_q;
  logic [IDX_W-1:0]          rc_nxt;
  logic                      out_hs;

  assign rc_nxt = rc_q + 1'b1;
  assign out_hs = out_valid & out_ready;
  assign done   = out_hs & out_last;

  // NOTE: the result buffer is a plain register bank, so it takes the async
  // reset like everything else; a reset must discard undrained results.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_buf_q <= '0;
      rc_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (capture) begin
      res_buf_q <= res;
      rc_q      <= '0;
      out_valid <= 1'b1;
      out_data  <= res[WORD_W-1:0];
      out_last  <= 1'b0;
    end else if (out_hs) begin
      rc_q <= rc_nxt;
      if (out_last) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        // Pre-register the next word so out_data comes straight from a flop.
        out_data <= res_buf_q[WORD_W*rc_nxt +: WORD_W];
        out_last <= (rc_nxt == IDX_W'(N_WORDS - 1));
      end
    end
  end

endmodule

// File: rtl/attn_io_stager.sv
// Stream front/back end for the 8x8 attention core: loads key/value/query,
// runs one enabled pass until done, then drains the result as 32 words.
// Optional RUN watchdog: define ATTN_STAGER_TIMEOUT_EN.
module attn_io_stager #(
  parameter int          WORD_W      = attn_pkg::WORD_W,
  parameter int          N_WORDS     = attn_pkg::N_WORDS,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  output logic [WORD_W*N_WORDS-1:0] core_key,
  output logic [WORD_W*N_WORDS-1:0] core_value,
  output logic [WORD_W*N_WORDS-1:0] core_query,
  output logic                      core_en,
  output logic                      core_rst_n,
  input  logic [WORD_W*N_WORDS-1:0] core_res,
  input  logic                      core_done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      err
);

  import attn_pkg::*;

  localparam int IDX_W = $clog2(N_WORDS);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 16-bit watchdog counter");
  end

  state_t           state_q;
  logic [6:0]       wc_q;
  logic             in_hs;
  logic             load_last;
  logic             capture;
  logic             ser_done;
  logic             timeout_hit;
  logic [IDX_W-1:0] slot;

  assign in_ready   = (state_q == ST_LOAD);
  assign core_en    = (state_q == ST_RUN);
  assign core_rst_n = ~rst;
  assign busy       = !((state_q == ST_LOAD) && (wc_q == 7'd0));

  assign in_hs     = in_valid & in_ready;
  assign load_last = in_hs && (wc_q == 7'(TOTAL_WORDS - 1));
  assign capture   = (state_q == ST_RUN) && core_done;
  // Operand bases are multiples of N_WORDS, so the low bits are the slot.
  assign slot      = wc_q[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      wc_q    <= '0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (load_last) begin
            wc_q    <= '0;
            state_q <= ST_RUN;
          end else if (in_hs) begin
            wc_q <= wc_q + 7'd1;
          end
        end
        ST_RUN: begin
          if (core_done)        state_q <= ST_DRAIN;
          else if (timeout_hit) state_q <= ST_LOAD;
        end
        ST_DRAIN: begin
          if (ser_done) state_q <= ST_LOAD;
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  // Operand buses only change on a LOAD handshake, so they hold through RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_key   <= '0;
      core_value <= '0;
      core_query <= '0;
    end else if (in_hs) begin
      unique case (op_sel(wc_q))
        SEL_KEY:   core_key[WORD_W*slot +: WORD_W]   <= in_data;
        SEL_VALUE: core_value[WORD_W*slot +: WORD_W] <= in_data;
        SEL_QUERY: core_query[WORD_W*slot +: WORD_W] <= in_data;
        default: ;
      endcase
    end
  end

`ifdef ATTN_STAGER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] tcnt_q;
  logic        err_q;

  // core_done in the expiry cycle wins, so the watchdog only fires without it.
  assign timeout_hit = (state_q == ST_RUN) && !core_done && (tcnt_q == TIMEOUT_LAST);
  assign err         = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= (state_q == ST_RUN) ? tcnt_q + 16'd1 : 16'd0;
      if (timeout_hit)  err_q <= 1'b1;
      else if (in_hs)   err_q <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  attn_out_serializer #(
    .WORD_W  (WORD_W),
    .N_WORDS (N_WORDS)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .res       (core_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_attn_io_stager.sv
// Scoreboard bench for attn_io_stager: loads jobs, models the core's done
// pulse and result, and checks the drained words against a queue.
`timescale 1ns/1ps
module tb_attn_io_stager;

  localparam int W  = 16;
  localparam int N  = 32;
  localparam int BW = W * N;
`ifdef ATTN_STAGER_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 4096;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [BW-1:0] core_key, core_value, core_query;
  logic [BW-1:0] core_res = '0;
  logic          core_en, core_rst_n;
  logic          core_done = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy, err;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]  sb[$];
  logic [BW-1:0] exp_key = '0, exp_value = '0, exp_query = '0;
  int            ready_mode = 0;
  int            pat_idx = 0;
  int            job_words = 0;
  int            last_seen = 0;
  int            valid_seen = 0;
  logic          stall_prev = 1'b0;
  logic [W-1:0]  stall_data = '0;

  attn_io_stager #(
    .WORD_W      (W),
    .N_WORDS     (N),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .core_key   (core_key),
    .core_value (core_value),
    .core_query (core_query),
    .core_en    (core_en),
    .core_rst_n (core_rst_n),
    .core_res   (core_res),
    .core_done  (core_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output side: drives out_ready, then judges the handshake at the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (ready_mode == 1) begin
        out_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
        pat_idx++;
      end else begin
        out_ready = 1'b1;
      end
      if (stall_prev) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, stall_data);
      end
      if (out_valid) begin
        valid_seen++;
        check("en_low_in_drain", core_en, 1'b0);
        if (out_ready) begin
          check("sb_nonempty", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            logic [W-1:0] e;
            e = sb.pop_front();
            check("out_data", out_data, e);
            check("out_last", out_last, job_words == N - 1);
            job_words++;
            if (out_last) last_seen++;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic load_job(input logic [W-1:0] base, input int start, input int n, input int done_at);
    int k = start;
    int guard = 0;
    logic [W-1:0] d;
    while (k < n && guard < 1000) begin
      cyc();
      guard++;
      d         = base + W'(k);
      in_valid  = 1'b1;
      in_data   = d;
      core_done = (k == done_at);
      if (done_at >= 0 && k == done_at + 1) begin
        check("done_ignored_ready", in_ready, 1'b1);
        check("done_ignored_en", core_en, 1'b0);
        check("busy_loading", busy, 1'b1);
      end
      if (in_ready) begin
        if (k == 3*N - 1) check("en_before_last", core_en, 1'b0);
        if (k < N)        exp_key[W*k +: W]         = d;
        else if (k < 2*N) exp_value[W*(k-N) +: W]   = d;
        else              exp_query[W*(k-2*N) +: W] = d;
        k++;
      end
    end
    if (k < n) check("load_timeout", k, n);
    cyc();
    in_valid  = 1'b0;
    core_done = 1'b0;
    if (n == 3*N) begin
      check("en_after_last", core_en, 1'b1);
      check("in_ready_run", in_ready, 1'b0);
      check("key_bus", core_key, exp_key);
      check("value_bus", core_value, exp_value);
      check("query_bus", core_query, exp_query);
    end
  endtask

  task automatic run_and_drain(input logic [W-1:0] res_base, input int mode, output int drain_cyc);
    int l0;
    l0       = last_seen;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    repeat (49) cyc();
    check("run_in_ready", in_ready, 1'b0);
    check("run_en", core_en, 1'b1);
    check("run_key_hold", core_key, exp_key);
    check("run_query_hold", core_query, exp_query);
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      core_res[W*i +: W] = res_base + W'(i);
      sb.push_back(res_base + W'(i));
    end
    ready_mode = mode;
    pat_idx    = 0;
    job_words  = 0;
    core_done  = 1'b1;
    cyc();
    core_done = 1'b0;
    core_res  = {16{$urandom}};
    check("first_valid", out_valid, 1'b1);
    check("en_drop", core_en, 1'b0);
    check("first_word", out_data, res_base);
    drain_cyc = 1;
    while (job_words < N && drain_cyc < 400) begin
      cyc();
      drain_cyc++;
    end
    check("drain_words", job_words, N);
    cyc();
    check("back_to_load", in_ready, 1'b1);
    check("idle_valid", out_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("last_once", last_seen - l0, 1);
    check("sb_empty", sb.size(), 0);
    ready_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d;
    // Reset values.
    cyc();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_core_en", core_en, 1'b0);
    check("rst_core_rst_n", core_rst_n, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 16'h0);
    check("rst_key", core_key, '0);
    check("rst_value", core_value, '0);
    check("rst_query", core_query, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    cyc();
    check("core_rst_n_rel", core_rst_n, 1'b1);

    // Job 1: counting pattern with a stray done pulse mid-load.
    load_job(16'h0001, 0, 3*N, 10);
    check("key_w0", core_key[15:0], 16'h0001);
    check("value_w0", core_value[15:0], 16'h0021);
    check("query_w31", core_query[BW-1 -: W], 16'h0060);
    run_and_drain(16'hA000, 0, d);
    check("drain_cycles", d, N);

    // Job 2: out_ready stalls 1,0,0,1.
    load_job(16'h1000, 0, 3*N, -1);
    run_and_drain(16'hB000, 1, d);

    // Reset in the middle of a load, then a fresh job.
    load_job(16'h2000, 0, 40, -1);
    check("partial_busy", busy, 1'b1);
    cyc();
    rst = 1'b1;
    #1;
    check("mid_rst_key", core_key, '0);
    check("mid_rst_value", core_value, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    exp_key = '0; exp_value = '0; exp_query = '0;
    cyc();
    rst = 1'b0;
    load_job(16'h3000, 0, 3*N, -1);
    check("reload_err", err, 1'b0);
    run_and_drain(16'hC000, 0, d);
    check("reload_drain_cycles", d, N);

`ifdef ATTN_STAGER_TIMEOUT_EN
    begin
      int en_cyc = 0;
      int v0;
      int guard = 0;
      load_job(16'h4000, 0, 3*N, -1);
      v0 = valid_seen;
      while (core_en && guard < 200) begin
        en_cyc++;
        guard++;
        cyc();
      end
      check("to_run_cycles", en_cyc, TO_CYC);
      check("to_err", err, 1'b1);
      check("to_en", core_en, 1'b0);
      check("to_ready", in_ready, 1'b1);
      cyc();
      check("to_err_sticky", err, 1'b1);
      check("to_no_output", valid_seen - v0, 0);
      in_valid = 1'b1;
      in_data  = 16'h5000;
      exp_key[W-1:0] = 16'h5000;
      cyc();
      in_valid = 1'b0;
      check("err_cleared", err, 1'b0);
      load_job(16'h5000, 1, 3*N, -1);
      run_and_drain(16'hD000, 0, d);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
